// File: rtl/cache_write_merge_ctrl_if.sv
// Store-port and line-writeback bus of the write-merge controller.
// The slave side is the controller; the master side is the processor/downstream.
interface cache_write_merge_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 128
);
  logic                   p_req;
  logic [ADDR_W-1:0]      p_addr;
  logic [3:0]             p_w_en;
  logic [31:0]            p_wdata;
  logic                   p_ready;
  logic                   flush;
  logic                   busy;
  logic                   wb_valid;
  logic [ADDR_W-5:0]      wb_addr;
  logic [LINE_BITS-1:0]   wb_data;
  logic [LINE_BITS/8-1:0] wb_strb;
  logic                   wb_ready;

  modport master (
    output p_req, p_addr, p_w_en, p_wdata, flush, wb_ready,
    input  p_ready, busy, wb_valid, wb_addr, wb_data, wb_strb
  );

  modport slave (
    input  p_req, p_addr, p_w_en, p_wdata, flush, wb_ready,
    output p_ready, busy, wb_valid, wb_addr, wb_data, wb_strb
  );
endinterface

// File: rtl/cache_write_merge_ctrl.sv
// Write-combining buffer: merges byte-masked word stores to one 16-byte line
// and drains it as a single strobed line write.
//
// state | meaning
// IDLE  | buffer empty, any store accepted
// MERGE | partial line held, hits merged, idle timer running
// DRAIN | line presented on wb_*, waiting for wb_ready
module cache_write_merge_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 128,
  parameter int TIMEOUT   = 16
) (
  input logic                     clk,
  input logic                     rst,
  cache_write_merge_ctrl_if.slave bus
);
  localparam int STRB_W = LINE_BITS / 8;
  localparam int WORDS  = LINE_BITS / 32;
  localparam int LA_W   = ADDR_W - 4;
  localparam int TMR_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MERGE, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [LINE_BITS-1:0] line_data, merged_data;
  logic [STRB_W-1:0]    line_strb, merged_strb;
  logic [LA_W-1:0]      line_addr;
  logic [TMR_W-1:0]     timer;
  logic [1:0]           word_sel;
  logic                 hit, accept, timeout, full;
  logic                 ready, valid, busy_int;

  assign word_sel = bus.p_addr[3:2];
  assign hit      = bus.p_req && (bus.p_addr[ADDR_W-1:4] == line_addr);
  assign timeout  = (timer == TMR_W'(TIMEOUT - 1));
  assign accept   = bus.p_req && ready;
  assign full     = (merged_strb == {STRB_W{1'b1}});

  // The buffer is all-zero in IDLE, so one merge path serves both load and hit.
  always_comb begin
    merged_data = line_data;
    merged_strb = line_strb;
    for (int k = 0; k < WORDS; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (word_sel == 2'(k) && bus.p_w_en[b]) begin
          merged_data[32*k + 8*b +: 8] = bus.p_wdata[8*b +: 8];
          merged_strb[4*k + b]         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (accept && (bus.p_w_en != 4'h0))
          state_nxt = full ? DRAIN : MERGE;
      MERGE:
        if (bus.flush)                 state_nxt = DRAIN;
        else if (bus.p_req && !hit)    state_nxt = DRAIN;
        else if (accept && full)       state_nxt = DRAIN;
        else if (!accept && timeout)   state_nxt = DRAIN;
      DRAIN:
        if (bus.wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    valid    = 1'b0;
    busy_int = 1'b1;
    case (state)
      IDLE: begin
        ready    = 1'b1;
        busy_int = 1'b0;
      end
      MERGE:   ready = !bus.flush && (!bus.p_req || hit);
      DRAIN:   valid = 1'b1;
      default: busy_int = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_data <= '0;
      line_strb <= '0;
      line_addr <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE:
          if (accept && (bus.p_w_en != 4'h0)) begin
            line_addr <= bus.p_addr[ADDR_W-1:4];
            line_data <= merged_data;
            line_strb <= merged_strb;
            timer     <= '0;
          end
        MERGE:
          if (accept) begin
            line_data <= merged_data;
            line_strb <= merged_strb;
            timer     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        DRAIN:
          if (bus.wb_ready) begin
            line_data <= '0;
            line_strb <= '0;
            timer     <= '0;
          end
        default: ;
      endcase
    end
  end

  assign bus.p_ready  = ready;
  assign bus.wb_valid = valid;
  assign bus.busy     = busy_int;
  assign bus.wb_addr  = line_addr;
  assign bus.wb_data  = line_data;
  assign bus.wb_strb  = line_strb;
endmodule

// File: doc/cache_write_merge_ctrl.md
Name: cache_write_merge_ctrl

Overview:
Write-combining controller between the processor store port and the cache data array / AXI write path. It merges byte-masked word stores that hit the same 16-byte cache line into one line buffer with per-byte strobes. It drains the line as a single 128-bit write with a 16-bit strobe when any of the following occurs:
- a store targets a different line,
- the line becomes fully written,
- an idle timeout expires,
- a flush is requested.

Parameters:
ADDR_W, 32, processor byte-address width
LINE_BITS, 128, cache line width in bits (4 words, 16 bytes)
TIMEOUT, 16, idle cycles in MERGE before a forced drain (must be >= 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
p_req  input  1  processor store valid
p_addr  input  ADDR_W  store byte address; [3:2] = word offset, [ADDR_W-1:4] = line address
p_w_en  input  4  byte write enables, bit i covers p_wdata[8i+7:8i]
p_wdata  input  32  store data
p_ready  output  1  store accepted this cycle when p_req && p_ready
flush  input  1  level request to drain any buffered line
busy  output  1  high whenever the buffer holds data (state != IDLE)
wb_valid  output  1  line write valid
wb_addr  output  ADDR_W-4  line address of drained line
wb_data  output  LINE_BITS  merged line data; unwritten bytes are 0
wb_strb  output  16  byte strobes; bit 4k+i = word k, byte i
wb_ready  input  1  downstream accepts line when wb_valid && wb_ready

Behaviour:
- Reset (rst=0, async): state=IDLE, line buffer=0, strobe=0, wb_addr=0, timer=0. All outputs 0 except p_ready=1.
- Lane mapping: word offset k places p_wdata in bits [32k+31:32k] and p_w_en in strobe bits [4k+3:4k]. Only bytes with p_w_en set are written; other bytes keep their buffered value.
- States: IDLE (empty), MERGE (partial line held), DRAIN (wb_valid=1).
- IDLE:
  - p_ready=1.
  - If flush=1, stay in IDLE; no wb transaction is issued.
  - On an accepted store with p_w_en!=0: load line address, buffer=masked data at lane k, strobe=p_w_en at lane k, timer=0.
    - Go to MERGE.
    - If the resulting strobe is 16'hFFFF, go to DRAIN instead (impossible from IDLE since only one lane is written).
  - An accepted store with p_w_en=0 is a no-op (accepted, no state change).
- MERGE:
  - hit = p_req && line(p_addr)==wb_addr.
  - p_ready = !flush && (!p_req || hit). The path from p_req to p_ready is combinational.
  - On a hit: merge bytes (newer store overwrites per byte), strobe |= new lanes, timer=0.
  - Priority, highest first:
    1. flush → DRAIN; the store is not accepted.
    2. miss (p_req && !hit) → DRAIN; the store is not accepted and the processor retries it later.
    3. strobe after merge == 16'hFFFF → DRAIN.
    4. timer == TIMEOUT-1 with no store accepted → DRAIN.
    5. otherwise stay in MERGE and increment timer when no store is accepted.
- DRAIN:
  - p_ready=0.
  - wb_valid=1. wb_addr, wb_data and wb_strb are registered and stay stable until the handshake.
  - On wb_ready: clear buffer and strobe, timer=0, go to IDLE. A store is never accepted in the handshake cycle.
- Latency:
  - Store to line visible in the buffer: 1 cycle.
  - Full line to wb_valid: 1 cycle after the completing store.
  - Miss to wb_valid: 1 cycle.
  - Minimum miss-store retry acceptance: 1 cycle after the wb handshake (IDLE).
- Reset asserted mid-DRAIN drops the buffered line without a wb transaction.
- busy = (state != IDLE).

Test Plan:
1. Reset, then one store: p_addr=0x1000_0004, p_w_en=4'hF, p_wdata=0xDEADBEEF. Hold flush=1 the next cycle → wb_valid=1, wb_addr=0x100_0000, wb_data=0x…0000_DEADBEEF_0000_0000 (word 1), wb_strb=16'h00F0; wb_ready=1 → IDLE, busy=0.
2. Four full-word stores to offsets 0..3 of line 0x2000_0000 (data 0x11111111..0x44444444) → wb_valid the cycle after the 4th store, wb_strb=16'hFFFF, wb_data=0x44444444_33333333_22222222_11111111.
3. Byte merge: p_addr=0x30, p_w_en=4'b0001, data 0x000000AA; then p_addr=0x30, p_w_en=4'b1000, data 0xBB000000; then flush → wb_data[31:0]=0xBB0000AA, wb_strb=16'h0009.
4. Miss: buffer holds line 0x40 (word 0). Store to 0x80 → p_ready=0 that cycle, DRAIN of line 0x40; hold wb_ready=0 for 3 cycles and check outputs stable and p_ready=0; after the handshake the retried store to 0x80 is accepted in IDLE.
5. Timeout with TIMEOUT=16: one store, then idle → wb_valid rises exactly 16 cycles after acceptance. A hit at cycle 10 restarts the count.
6. Async reset pulse while wb_valid=1 → wb_valid, busy and wb_strb go to 0 immediately, p_ready=1, and no handshake completes.
